spi_slave_port: RTL
===================

// Module: spi_slave_port
// PURPOSE
// - SPI mode-0 (CPOL=0, CPHA=0) slave byte engine, MSB first. Sits between the external SPI pins and spi_memory.
// - Synchronises the asynchronous SCK/MOSI/CS_N pins into clk and assembles received bytes.
// - Provides received bytes as dout with a one-cycle done strobe, plus a selected level.
// - Serialises din onto MISO for the following byte.
// PARAMETERS
// - SYNC_STAGES   2   flip-flop stages on each of sck, mosi, cs_n (legal >= 2)
// PORTS
// - clk       in   1  system clock; all logic on posedge; f_clk >= 8 x f_sck
// - rst       in   1  synchronous reset, active-low (0 = held in reset)
// - sck       in   1  SPI clock pin, asynchronous to clk
// - mosi      in   1  SPI data in pin, asynchronous
// - cs_n      in   1  SPI chip select pin, active-low, asynchronous
// - miso      out  1  SPI data out (registered)
// - miso_oe   out  1  MISO output enable for top-level tristate; equals selected
// - dout      out  8  last fully received byte; held until next done
// - din       in   8  byte to transmit next; sampled at byte boundaries
// - done      out  1  one-clk pulse: dout updated with a new complete byte
// - selected  out  1  synchronised CS active level
// BEHAVIOUR
// - Reset (rst==0): miso=0, miso_oe=0, dout=8'h00, done=0, selected=0, bit_cnt=0, rx/tx shift=0.
//   Edge-detect history regs load their idle values (sck=0, cs_n=1) so no spurious edge after reset.
// - Sync: each pin passes SYNC_STAGES FFs; one more history FF per sck/cs_n gives rise/fall detect.
// - selected = ~cs_n_sync. Pin change -> selected change: SYNC_STAGES+1 clk cycles.
// - CS assert (sync falling cs_n): bit_cnt<=0, rx_shift<=0, tx_shift<=din, miso<=din[7].
// - SCK rise while selected: rx_shift<={rx_shift[6:0],mosi_sync}; bit_cnt<=bit_cnt+1 (3-bit, wraps 7->0).
//   On the rise where bit_cnt==7: next cycle dout<={rx_shift[6:0],mosi_sync}, done=1 for exactly 1 clk.
//   Pin 8th rising edge -> done: SYNC_STAGES+2 clk cycles.
// - SCK fall while selected:
//   bit_cnt!=0: tx_shift<=tx_shift<<1; miso<=tx_shift[6].
//   bit_cnt==0 (byte boundary): tx_shift<=din; miso<=din[7]. Consumer must present din within 3 clk after done.
// - SCK edges while not selected: ignored; no shifting, no counting.
// - CS deassert (sync rising cs_n): bit_cnt<=0, partial byte discarded, no done, dout unchanged;
//   miso<=0, miso_oe<=0 on the same cycle selected drops.
// - Same-cycle CS deassert and SCK rise: deassert wins; no shift, no done.
// - done is never asserted while selected==0; done never asserted two cycles in a row.
// - rst mid-byte: all state per reset list; next byte starts only after a fresh CS assert edge.
// - No framing on byte count: any number of bytes per CS window, each produces one done.
// TESTING
// - CS low, send 8'hA5 at f_sck=f_clk/8 -> one done pulse, dout=8'hA5, selected=1 throughout.
// - din=8'h3C held, CS low, send 2 bytes 8'h80,8'h01 -> MISO reads 8'h3C then 8'h3C; dout 8'h80 then 8'h01.
// - Back-to-back bytes 8'h12,8'h34,8'h56 in one CS window, din changed to 8'hC3 after first done
//   -> 3 done pulses; 2nd MISO byte=8'hC3.
// - CS deassert after 5 SCK rises -> no done, dout keeps previous value, miso_oe=0 within SYNC_STAGES+1 clk.
// - rst=0 mid-byte after 3 SCK rises -> all outputs at reset values; new CS window byte 8'hFF received exactly.
// - SCK toggling with cs_n=1 -> done never asserts, miso=0, miso_oe=0.

Source files
------------

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave byte engine: synchronises pins into clk, assembles MSB-first bytes, serialises din onto MISO.
// Latency: selected follows cs_n pin by SYNC_STAGES+1 clk; done follows the 8th SCK rise by SYNC_STAGES+2 clk.
module spi_slave_port #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] dout,
  input  logic [7:0] din,
  output logic       done,
  output logic       selected
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_hist;
  logic                   r_cs_hist;

  logic       w_sck_s;
  logic       w_mosi_s;
  logic       w_cs_s;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_dout;
  logic       r_miso;
  logic       r_done;
  logic       r_pend;
  logic       r_selected;

  // History regs reset to idle pin levels so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_hist  <= 1'b0;
      r_cs_hist   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_hist  <= w_sck_s;
      r_cs_hist   <= w_cs_s;
    end
  end

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_hist;
  assign w_sck_fall = ~w_sck_s & r_sck_hist;
  assign w_cs_fall  = r_cs_hist & ~w_cs_s;
  assign w_cs_rise  = ~r_cs_hist & w_cs_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_dout     <= 8'h00;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_pend     <= 1'b0;
      r_selected <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pend <= 1'b0;
      // A byte completed last cycle is dropped if CS releases before it is published.
      if (r_pend && !w_cs_rise) begin
        r_dout <= r_rx_shift;
        r_done <= 1'b1;
      end
      if (w_cs_fall) begin
        r_selected <= 1'b1;
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_tx_shift <= din;
        r_miso     <= din[7];
      end else if (w_cs_rise) begin
        r_selected <= 1'b0;
        r_bit_cnt  <= 3'd0;
        r_miso     <= 1'b0;
      end else if (r_selected) begin
        if (w_sck_rise) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          r_pend     <= (r_bit_cnt == 3'd7);
        end else if (w_sck_fall) begin
          if (r_bit_cnt == 3'd0) begin
            r_tx_shift <= din;
            r_miso     <= din[7];
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            r_miso     <= r_tx_shift[6];
          end
        end
      end
    end
  end

  assign miso     = r_miso;
  assign miso_oe  = r_selected;
  assign dout     = r_dout;
  assign done     = r_done;
  assign selected = r_selected;

endmodule
